// File: rtl/fft_apb_master.sv
// fft_apb_master: command/response front end driving a single APB initiator.
// Define FFT_APB_TIMEOUT_EN to abort ACCESS phases after TIMEOUT_CYCLES wait cycles.
module fft_apb_master #(
    parameter int APB_ADDR_WIDTH = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      pclk_i,
    input  logic                      preset_n_i,
    input  logic                      cmd_valid_i,
    output logic                      cmd_ready_o,
    input  logic                      cmd_write_i,
    input  logic [APB_ADDR_WIDTH-1:0] cmd_addr_i,
    input  logic [31:0]               cmd_wdata_i,
    output logic                      rsp_valid_o,
    input  logic                      rsp_ready_i,
    output logic [31:0]               rsp_rdata_o,
    output logic                      rsp_err_o,
    output logic                      psel_o,
    output logic                      penable_o,
    output logic                      pwrite_o,
    output logic [APB_ADDR_WIDTH-1:0] paddr_o,
    output logic [31:0]               pwdata_o,
    input  logic [31:0]               prdata_i,
    input  logic                      pready_i
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 1..255");
    end

    state_t                    state, state_nx;
    logic [APB_ADDR_WIDTH-1:0] addr_q;
    logic [31:0]               wdata_q, rdata_q;
    logic                      write_q, accept, done, timeout;

    assign accept = state == IDLE && cmd_valid_i;
    assign done   = state == ACCESS && (pready_i || timeout);

`ifdef FFT_APB_TIMEOUT_EN
    logic [7:0] cnt;
    logic       err_q;
    assign timeout   = cnt == 8'(TIMEOUT_CYCLES - 1);
    assign rsp_err_o = err_q;
    always_ff @(posedge pclk_i or negedge preset_n_i) begin
        if (!preset_n_i) begin
            cnt   <= '0;
            err_q <= 1'b0;
        end else begin
            if (state == SETUP) cnt <= '0;
            else if (state == ACCESS && !pready_i) cnt <= cnt + 8'd1;
            // pready_i on the final counted cycle still completes normally
            if (done) err_q <= !pready_i;
        end
    end
`else
    assign timeout   = 1'b0;
    assign rsp_err_o = 1'b0;
`endif

    always_ff @(posedge pclk_i or negedge preset_n_i) begin
        if (!preset_n_i) state <= IDLE;
        else state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = cmd_valid_i ? SETUP : IDLE;
            SETUP:   state_nx = ACCESS;
            ACCESS:  state_nx = done ? RESP : ACCESS;
            default: state_nx = rsp_ready_i ? IDLE : RESP;
        endcase
    end

    always_ff @(posedge pclk_i or negedge preset_n_i) begin
        if (!preset_n_i) begin
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            if (accept) begin
                addr_q  <= cmd_addr_i;
                wdata_q <= cmd_wdata_i;
                write_q <= cmd_write_i;
            end
            if (done) rdata_q <= (write_q || !pready_i) ? '0 : prdata_i;
        end
    end

    assign cmd_ready_o = state == IDLE;
    assign psel_o      = state == SETUP || state == ACCESS;
    assign penable_o   = state == ACCESS;
    assign rsp_valid_o = state == RESP;
    assign rsp_rdata_o = rdata_q;
    assign paddr_o     = state == IDLE ? '0 : addr_q;
    assign pwdata_o    = state == IDLE ? '0 : wdata_q;
    assign pwrite_o    = state != IDLE && write_q;
endmodule

// File: tb/tb_fft_apb_master.sv
// tb_fft_apb_master: directed stimulus with a response scoreboard and an APB slave model.
module tb_fft_apb_master;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [15:0] cmd_addr = '0, paddr;
    logic [31:0] cmd_wdata = '0, rsp_rdata, pwdata, prdata;
    logic        rsp_valid, rsp_ready = 1'b1, rsp_err;
    logic        psel, penable, pwrite, pready;

    int          tests = 0, fails = 0;
    int          delay = 0, acc_cnt = 0;
    logic        never = 1'b0;
    logic [31:0] rd_val = '0;

    typedef struct packed {logic [31:0] rdata; logic err;} rsp_t;
    rsp_t exp_q[$];

    always #5 clk = ~clk;

    fft_apb_master #(.APB_ADDR_WIDTH(16), .TIMEOUT_CYCLES(8)) dut (
        .pclk_i(clk), .preset_n_i(rst_n),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_write_i(cmd_write),
        .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
        .psel_o(psel), .penable_o(penable), .pwrite_o(pwrite),
        .paddr_o(paddr), .pwdata_o(pwdata), .prdata_i(prdata), .pready_i(pready)
    );

    // slave model: ready after `delay` wait cycles in ACCESS
    always @(posedge clk) acc_cnt <= (penable && !pready) ? acc_cnt + 1 : 0;
    assign pready = penable && !never && acc_cnt >= delay;
    assign prdata = rd_val;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) chk("unexpected_rsp", 32'd1, 32'd0);
            else begin
                rsp_t e;
                e = exp_q.pop_front();
                chk("rsp_rdata", rsp_rdata, e.rdata);
                chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // returns one cycle after acceptance, with the DUT in SETUP
    task automatic send(input logic w, input logic [15:0] a, input logic [31:0] d);
        int n = 0;
        cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_valid = 1'b1;
        while (!cmd_ready && n < 50) begin tick(); n++; end
        chk("accept_bound", {31'd0, n < 50}, 32'd1);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!cmd_ready && n < 50) begin tick(); n++; end
        chk("idle_bound", {31'd0, n < 50}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   pen, n;
        logic stable;
        #3;
        chk("rst_outputs", {psel, penable, rsp_valid, pwrite, rsp_err}, 32'd0);
        chk("rst_paddr", {16'd0, paddr}, 32'd0);
        chk("rst_rdata", rsp_rdata, 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);

        // write, immediate pready: SETUP, ACCESS, RESP three cycles after accept
        delay = 0;
        exp_q.push_back('{rdata: 32'd0, err: 1'b0});
        send(1'b1, 16'h0004, 32'h000A0000);
        chk("w_setup", {30'd0, psel, penable}, 32'b10);
        chk("w_paddr", {16'd0, paddr}, 32'h4);
        chk("w_pwdata", pwdata, 32'h000A0000);
        chk("w_pwrite", {31'd0, pwrite}, 32'd1);
        tick();
        chk("w_access", {30'd0, psel, penable}, 32'b11);
        tick();
        chk("w_resp", {29'd0, rsp_valid, psel, penable}, 32'b100);
        wait_idle();
        chk("idle_paddr", {16'd0, paddr}, 32'd0);

        // read with 4 wait cycles
        delay = 4; rd_val = 32'h000000A5;
        exp_q.push_back('{rdata: 32'h000000A5, err: 1'b0});
        send(1'b0, 16'h0018, 32'h0);
        pen = 0; n = 0; stable = 1'b1;
        while (psel && n < 30) begin
            if (penable) pen++;
            if (paddr != 16'h0018 || pwrite) stable = 1'b0;
            tick(); n++;
        end
        chk("r_penable_cycles", pen, 32'd5);
        chk("r_addr_stable", {31'd0, stable}, 32'd1);
        chk("r_resp_valid", {31'd0, rsp_valid}, 32'd1);
        wait_idle();

        // response backpressure while a new command waits
        delay = 0; rd_val = 32'h5A5A1234; rsp_ready = 1'b0;
        exp_q.push_back('{rdata: 32'h5A5A1234, err: 1'b0});
        exp_q.push_back('{rdata: 32'd0, err: 1'b0});
        send(1'b0, 16'h0020, 32'h0);
        tick(); tick();
        cmd_write = 1'b1; cmd_addr = 16'h0030; cmd_wdata = 32'h11; cmd_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("bp_cmd_ready", {31'd0, cmd_ready}, 32'd0);
            chk("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("bp_rsp_rdata", rsp_rdata, 32'h5A5A1234);
            tick();
        end
        rsp_ready = 1'b1;
        chk("bp_hs_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        tick();
        chk("bp_idle_ready", {31'd0, cmd_ready}, 32'd1);
        tick();
        cmd_valid = 1'b0;
        chk("bp_next_setup", {30'd0, psel, penable}, 32'b10);
        chk("bp_next_paddr", {16'd0, paddr}, 32'h30);
        wait_idle();

`ifdef FFT_APB_TIMEOUT_EN
        // slave never ready: abort after 8 ACCESS cycles with an error response
        never = 1'b1; rd_val = 32'hFFFFFFFF;
        exp_q.push_back('{rdata: 32'd0, err: 1'b1});
        send(1'b0, 16'h0050, 32'h0);
        n = 0;
        tick();
        while (penable && n < 300) begin n++; tick(); end
        chk("to_access_cycles", n, 32'd8);
        chk("to_psel_low", {31'd0, psel}, 32'd0);
        chk("to_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        never = 1'b0;
        wait_idle();
`endif

        // reset mid-ACCESS drops the transfer without a response
        delay = 10;
        send(1'b0, 16'h0040, 32'h0);
        tick();
        chk("rst_mid_access", {31'd0, penable}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_outputs", {29'd0, psel, penable, rsp_valid}, 32'd0);
        tick();
        #2 rst_n = 1'b1;
        tick();
        chk("rst_release_ready", {31'd0, cmd_ready}, 32'd1);
        for (int i = 0; i < 5; i++) tick();
        delay = 0;
        exp_q.push_back('{rdata: 32'd0, err: 1'b0});
        send(1'b1, 16'h0044, 32'h0000DEAD);
        chk("post_rst_paddr", {16'd0, paddr}, 32'h44);
        wait_idle();

        // back-to-back writes, SETUP phases four cycles apart
        exp_q.push_back('{rdata: 32'd0, err: 1'b0});
        exp_q.push_back('{rdata: 32'd0, err: 1'b0});
        send(1'b1, 16'h0000, 32'h1);
        chk("b2b_first_paddr", {16'd0, paddr}, 32'h0);
        cmd_write = 1'b1; cmd_addr = 16'h0010; cmd_wdata = 32'h2; cmd_valid = 1'b1;
        n = 0;
        do begin tick(); n++; end while (!(psel && !penable) && n < 20);
        cmd_valid = 1'b0;
        chk("b2b_spacing", n, 32'd4);
        chk("b2b_second_paddr", {16'd0, paddr}, 32'h10);
        wait_idle();
        tick(); tick();
        chk("scoreboard_empty", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
